// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - control/handshake bundle between the sequencer and the shared datapath
//
// master : the sequencer. Reads opcode, decoder indications and mem_ready;
//          drives memory request, register enables and status.
// slave  : the datapath/memory side, the mirror image of master.
interface multicycle_sequencer_if #(
    parameter int INSTRET_WIDTH = 64
) ();
    logic [6:0]               opcode;
    logic                     dec_we_memory;
    logic                     dec_we_gpr;
    logic                     mem_ready;
    logic                     mem_req;
    logic                     mem_we;
    logic                     mem_addr_sel;
    logic                     ir_we;
    logic                     opnd_we;
    logic                     alu_res_we;
    logic                     gpr_we;
    logic                     pc_we;
    logic [2:0]               state;
    logic                     busy;
    logic                     illegal;
    logic                     mem_fault;
    logic [INSTRET_WIDTH-1:0] instret;

    modport master (
        input  opcode, dec_we_memory, dec_we_gpr, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_we, opnd_we, alu_res_we,
               gpr_we, pc_we, state, busy, illegal, mem_fault, instret
    );

    modport slave (
        output opcode, dec_we_memory, dec_we_gpr, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_we, opnd_we, alu_res_we,
               gpr_we, pc_we, state, busy, illegal, mem_fault, instret
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - FSM sequencing fetch/decode/execute/memory/writeback of a multi-cycle RV64I core
//
// Ports:
//   i_clk  : core clock
//   i_rst  : synchronous active-high reset
//   bus    : master side of multicycle_sequencer_if (opcode, decoder hints,
//            memory handshake, register enables, state/busy/illegal/
//            mem_fault status, retired-instruction counter)
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT   = 16,
    parameter int INSTRET_WIDTH = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    multicycle_sequencer_if.master      bus
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_OPIMM     = 7'b0010011;
    localparam logic [6:0] OP_OP        = 7'b0110011;
    localparam logic [6:0] OP_OPIMM32   = 7'b0011011;
    localparam logic [6:0] OP_OP32      = 7'b0111011;

    // Last counter value before the request has waited MEM_TIMEOUT cycles.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [7:0]               r_wait_cnt;
    logic [INSTRET_WIDTH-1:0] r_instret;
    logic                     r_illegal;
    logic                     r_mem_fault;

    logic w_mem_req;
    logic w_mem_we;
    logic w_mem_addr_sel;
    logic w_ir_we;
    logic w_opnd_we;
    logic w_alu_res_we;
    logic w_gpr_we;
    logic w_pc_we;
    logic w_set_illegal;
    logic w_set_fault;
    logic w_legal;
    logic w_timed_out;

    always_comb begin
        w_legal = 1'b0;
        case (bus.opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_OPIMM, OP_OP, OP_OPIMM32, OP_OP32: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    // Only meaningful while a request is outstanding; ready in the same
    // cycle takes priority because it is checked first below.
    assign w_timed_out = (r_wait_cnt == WAIT_LAST);

    always_comb begin
        w_next         = r_state;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_we        = 1'b0;
        w_opnd_we      = 1'b0;
        w_alu_res_we   = 1'b0;
        w_gpr_we       = 1'b0;
        w_pc_we        = 1'b0;
        w_set_illegal  = 1'b0;
        w_set_fault    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timed_out) begin
                    w_set_fault = 1'b1;
                    w_next      = S_HALT;
                end
            end
            S_DECODE: begin
                w_opnd_we = 1'b1;
                if (w_legal) begin
                    w_next = S_EXECUTE;
                end else begin
                    w_set_illegal = 1'b1;
                    w_next        = S_HALT;
                end
            end
            S_EXECUTE: begin
                w_alu_res_we = 1'b1;
                if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) begin
                    w_next = S_MEMORY;
                end else if (bus.opcode == OP_BRANCH) begin
                    w_pc_we = 1'b1;
                    w_next  = S_FETCH;
                end else begin
                    w_next = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = bus.dec_we_memory;
                if (bus.mem_ready) begin
                    if (bus.opcode == OP_STORE) begin
                        w_pc_we = 1'b1;
                        w_next  = S_FETCH;
                    end else begin
                        w_next = S_WRITEBACK;
                    end
                end else if (w_timed_out) begin
                    w_set_fault = 1'b1;
                    w_next      = S_HALT;
                end
            end
            S_WRITEBACK: begin
                w_gpr_we = bus.dec_we_gpr;
                w_pc_we  = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                // Unused encodings recover by refetching.
                w_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_FETCH;
            r_wait_cnt  <= 8'd0;
            r_instret   <= '0;
            r_illegal   <= 1'b0;
            r_mem_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait_cnt <= 8'd0;
            end else if (w_mem_req && !bus.mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            // pc_we marks the final cycle of every retiring instruction.
            if (w_pc_we) begin
                r_instret <= r_instret + INSTRET_WIDTH'(1);
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_fault) begin
                r_mem_fault <= 1'b1;
            end
        end
    end

    assign bus.mem_req      = w_mem_req;
    assign bus.mem_we       = w_mem_we;
    assign bus.mem_addr_sel = w_mem_addr_sel;
    assign bus.ir_we        = w_ir_we;
    assign bus.opnd_we      = w_opnd_we;
    assign bus.alu_res_we   = w_alu_res_we;
    assign bus.gpr_we       = w_gpr_we;
    assign bus.pc_we        = w_pc_we;
    assign bus.state        = r_state;
    assign bus.busy         = (r_state != S_HALT);
    assign bus.illegal      = r_illegal;
    assign bus.mem_fault    = r_mem_fault;
    assign bus.instret      = r_instret;

endmodule
